mag_tape_xport: RTL and testbench

//   Magnetic tape transport emulator; sits directly downstream of the G-15 magnetic tape control.
//   - Consumes MAG_TAPE_FWD, MAG_TAPE_REV and MAG6_OUT, and sequences start/run/stop motion.
//   - Tracks tape position and moves one 6-bit character per CHAR_PERIOD to/from an external tape-image store.
//   - Returns read characters and status (BOT/EOT/busy/overrun) to the computer side.

---
 rtl/mag_tape_xport.sv | 210 +++++++++++++++++++++
 tb/tb_mag_tape_xport.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mag_tape_xport.sv
// mag_tape_xport -- magnetic tape transport emulator behind the G-15 tape control.
//   Sequences IDLE/START/RUN/STOP motion from the FWD/REV command levels, keeps
//   the tape position, and moves one 6-bit character per CHAR_PERIOD clocks
//   between the computer side and an external tape-image store.
//
// Build option:
//   MAG_TAPE_REWIND_EN  adds the REWIND input and a fast REW state that
//                       walks pos down one per clock to BOT, then stops.
//
// Ports:
//   CLOCK, rst                 clock, async active-high reset
//   MAG_TAPE_FWD/REV           motion command levels (both set = no command)
//   MAG6_OUT, WR_CHAR          write gate and write character
//   REWIND                     rewind request (MAG_TAPE_REWIND_EN only)
//   TAPE_ADDR                  store address = current position
//   TAPE_RD_REQ/WR_REQ         store requests, held until TAPE_ACK
//   TAPE_WDATA                 store write data
//   TAPE_RDATA, TAPE_ACK       store read data and one-cycle acknowledge
//   TAPE_CHAR, TAPE_CHAR_RDY   last read character and its update pulse
//   TAPE_BUSY                  not IDLE
//   TAPE_BOT/EOT               position at first/last character
//   TAPE_OVERRUN               sticky, store missed a character slot
module mag_tape_xport #(
  parameter int CHAR_PERIOD = 1000,
  parameter int START_DELAY = 5000,
  parameter int STOP_DELAY  = 5000,
  parameter int ADDR_W      = 16,
  parameter int TAPE_LEN    = 65536
) (
  input  logic              CLOCK,
  input  logic              rst,
  input  logic              MAG_TAPE_FWD,
  input  logic              MAG_TAPE_REV,
  input  logic              MAG6_OUT,
  input  logic [5:0]        WR_CHAR,
`ifdef MAG_TAPE_REWIND_EN
  input  logic              REWIND,
`endif
  output logic [ADDR_W-1:0] TAPE_ADDR,
  output logic              TAPE_RD_REQ,
  output logic              TAPE_WR_REQ,
  output logic [5:0]        TAPE_WDATA,
  input  logic [5:0]        TAPE_RDATA,
  input  logic              TAPE_ACK,
  output logic [5:0]        TAPE_CHAR,
  output logic              TAPE_CHAR_RDY,
  output logic              TAPE_BUSY,
  output logic              TAPE_BOT,
  output logic              TAPE_EOT,
  output logic              TAPE_OVERRUN
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
`ifdef MAG_TAPE_REWIND_EN
  localparam logic [2:0] S_REW   = 3'd4;
`endif

  localparam int SLOT_W  = $clog2(CHAR_PERIOD);
  localparam int DLY_MAX = (START_DELAY > STOP_DELAY) ? START_DELAY : STOP_DELAY;
  localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;

  localparam logic [ADDR_W-1:0] EOT_POS   = ADDR_W'(TAPE_LEN - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CHAR_PERIOD - 1);
  localparam logic [DLY_W-1:0]  START_LST = DLY_W'(START_DELAY - 1);
  localparam logic [DLY_W-1:0]  STOP_LST  = DLY_W'(STOP_DELAY - 1);

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [5:0] wdata;
  } store_req_t;

  logic [2:0]        state;
  logic [ADDR_W-1:0] pos;
  logic              dir;          // 1 = reverse
  logic [SLOT_W-1:0] slot_cnt;
  logic [DLY_W-1:0]  dly_cnt;
  store_req_t        req;
  logic [5:0]        rchar;
  logic              char_rdy;
  logic              overrun;

  logic cmd_vld, cmd_same, at_bot, at_eot, run_limit, slot_end, req_pend, ack_ok, want_wr;

  assign cmd_vld   = MAG_TAPE_FWD ^ MAG_TAPE_REV;
  // Command still asserted with the direction latched at accept time.
  assign cmd_same  = cmd_vld && (MAG_TAPE_REV == dir);
  assign at_bot    = (pos == '0);
  assign at_eot    = (pos == EOT_POS);
  assign run_limit = dir ? at_bot : at_eot;
  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign req_pend  = req.rd | req.wr;
  assign ack_ok    = TAPE_ACK & req_pend;
  // Reverse motion never writes, whatever the write gate says.
  assign want_wr   = !dir && MAG6_OUT;

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pos      <= '0;
      dir      <= 1'b0;
      slot_cnt <= '0;
      dly_cnt  <= '0;
      req      <= '0;
      rchar    <= '0;
      char_rdy <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      char_rdy <= 1'b0;

      if (ack_ok) begin
        req.rd <= 1'b0;
        req.wr <= 1'b0;
        if (req.rd) begin
          rchar    <= TAPE_RDATA;
          char_rdy <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
`ifdef MAG_TAPE_REWIND_EN
          if (REWIND && !at_bot) begin
            state <= S_REW;
          end else
`endif
          if (cmd_vld && !(MAG_TAPE_REV ? at_bot : at_eot)) begin
            state   <= S_START;
            dir     <= MAG_TAPE_REV;
            dly_cnt <= '0;
          end
        end

        S_START: begin
          if (!cmd_same) begin
            state   <= S_STOP;
            dly_cnt <= '0;
          end else if (dly_cnt == START_LST) begin
            state     <= S_RUN;
            slot_cnt  <= '0;
            overrun   <= 1'b0;
            req.rd    <= !want_wr;
            req.wr    <= want_wr;
            req.wdata <= WR_CHAR;
          end else begin
            dly_cnt <= dly_cnt + DLY_W'(1);
          end
        end

        S_RUN: begin
          if (!slot_end) begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
          end else begin
            // An ACK on this very cycle is still in time.
            if (req_pend && !TAPE_ACK) begin
              req.rd  <= 1'b0;
              req.wr  <= 1'b0;
              overrun <= 1'b1;
            end
            if (!run_limit)
              pos <= dir ? pos - ADDR_W'(1) : pos + ADDR_W'(1);
            if (run_limit || !cmd_same) begin
              state   <= S_STOP;
              dly_cnt <= '0;
            end else begin
              // Next slot's request overrides the clear above.
              slot_cnt  <= '0;
              req.rd    <= !want_wr;
              req.wr    <= want_wr;
              req.wdata <= WR_CHAR;
            end
          end
        end

        S_STOP: begin
          if (dly_cnt == STOP_LST) state <= S_IDLE;
          else                     dly_cnt <= dly_cnt + DLY_W'(1);
        end

`ifdef MAG_TAPE_REWIND_EN
        S_REW: begin
          if (at_bot) begin
            state   <= S_STOP;
            dly_cnt <= '0;
          end else begin
            pos <= pos - ADDR_W'(1);
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

  assign TAPE_ADDR     = pos;
  assign TAPE_RD_REQ   = req.rd;
  assign TAPE_WR_REQ   = req.wr;
  assign TAPE_WDATA    = req.wdata;
  assign TAPE_CHAR     = rchar;
  assign TAPE_CHAR_RDY = char_rdy;
  assign TAPE_BUSY     = (state != S_IDLE);
  assign TAPE_BOT      = at_bot;
  assign TAPE_EOT      = at_eot;
  assign TAPE_OVERRUN  = overrun;

endmodule

// File: tb/tb_mag_tape_xport.sv
// Bench for mag_tape_xport with a small tape (16 chars, 8-clock slots, 4-clock
// start/stop). A store model ACKs 2 clocks after a request; read characters
// expected on TAPE_CHAR are queued up front and popped on each TAPE_CHAR_RDY.
module tb_mag_tape_xport;
  localparam int CP = 8, SD = 4, PD = 4, AW = 4, TL = 16;

  logic          CLOCK = 1'b0;
  logic          rst = 1'b1, fwd = 1'b0, rev = 1'b0, mag6 = 1'b0;
  logic [5:0]    wr_char = '0;
  logic [AW-1:0] addr;
  logic          rd_req, wr_req;
  logic [5:0]    wdata;
  logic [5:0]    rdata = '0;
  logic          ack = 1'b0;
  logic [5:0]    tchar;
  logic          rdy, busy, bot, eot, ovr;
`ifdef MAG_TAPE_REWIND_EN
  logic          rewind = 1'b0;
`endif

  int         errors = 0, checks = 0;
  logic [5:0] mem [TL];
  bit         ack_en = 1'b1, sb_on = 1'b0;
  logic [5:0] sb_q [$];
  int         lat = 0;

  mag_tape_xport #(.CHAR_PERIOD(CP), .START_DELAY(SD), .STOP_DELAY(PD),
                   .ADDR_W(AW), .TAPE_LEN(TL)) dut (
    .CLOCK(CLOCK), .rst(rst), .MAG_TAPE_FWD(fwd), .MAG_TAPE_REV(rev),
    .MAG6_OUT(mag6), .WR_CHAR(wr_char),
`ifdef MAG_TAPE_REWIND_EN
    .REWIND(rewind),
`endif
    .TAPE_ADDR(addr), .TAPE_RD_REQ(rd_req), .TAPE_WR_REQ(wr_req),
    .TAPE_WDATA(wdata), .TAPE_RDATA(rdata), .TAPE_ACK(ack),
    .TAPE_CHAR(tchar), .TAPE_CHAR_RDY(rdy), .TAPE_BUSY(busy),
    .TAPE_BOT(bot), .TAPE_EOT(eot), .TAPE_OVERRUN(ovr));

  always #5 CLOCK = ~CLOCK;

  // Store model: ACK (one cycle) on the second falling edge of a pending request.
  always @(negedge CLOCK) begin
    if (ack) begin
      ack = 1'b0;
      lat = 0;
    end else if ((rd_req || wr_req) && ack_en) begin
      lat++;
      if (lat == 2) begin
        if (wr_req) mem[addr] = wdata;
        rdata = mem[addr];
        ack = 1'b1;
      end
    end else begin
      lat = 0;
    end
  end

  // Scoreboard: every TAPE_CHAR_RDY pulse must match the next queued character.
  always @(negedge CLOCK) begin
    if (sb_on && rdy) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_rdy: got char %o, none expected", tchar);
      end else if (tchar !== sb_q[0]) begin
        errors++;
        $display("FAIL sb_char: got %o want %o", tchar, sb_q[0]);
        void'(sb_q.pop_front());
      end else begin
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic pulse_rst;
    rst = 1'b1; fwd = 1'b0; rev = 1'b0; mag6 = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin tick(); n++; end while (busy && n < 100);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle_timeout: busy=%b want 0", nm, busy); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (bot !== 1'b1)  begin errors++; $display("FAIL rst_bot: got %b want 1", bot); end
    checks++; if ({rd_req, wr_req, rdy, ovr, eot} !== 5'b0) begin errors++; $display("FAIL rst_flags: got %b want 00000", {rd_req, wr_req, rdy, ovr, eot}); end
    checks++; if (addr !== '0 || tchar !== '0) begin errors++; $display("FAIL rst_addr_char: got %0d/%o want 0/0", addr, tchar); end
    tick(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fwd_read;
    int n, c;
    for (int i = 0; i < TL; i++) begin mem[i] = 6'(i); sb_q.push_back(6'(i)); end
    sb_on = 1'b1; ack_en = 1'b1;
    fwd = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!rd_req && n < 20);
    checks++; if (n !== 5) begin errors++; $display("FAIL first_req_latency: got %0d want 5", n); end
    checks++; if (addr !== 4'd0) begin errors++; $display("FAIL first_req_addr: got %0d want 0", addr); end
    for (int k = 0; k < 3; k++) begin
      c = 0;
      do begin tick(); c++; end while (!rdy && c < 30);
      checks++; if (c !== ((k == 0) ? 2 : 8)) begin errors++; $display("FAIL rdy_spacing%0d: got %0d want %0d", k, c, (k == 0) ? 2 : 8); end
      checks++; if (addr !== AW'(k) || busy !== 1'b1) begin errors++; $display("FAIL run_addr%0d: got addr %0d busy %b want %0d 1", k, addr, busy, k); end
      checks++; if (bot !== (k == 0)) begin errors++; $display("FAIL run_bot%0d: got %b want %b", k, bot, k == 0); end
    end
  endtask

  task automatic test_run_to_eot;
    int n = 0, lastr = 0;
    do begin
      tick(); n++;
      if (rdy) lastr = n;
    end while (busy && n < 300);
    checks++; if (n - lastr !== 10) begin errors++; $display("FAIL eot_stop_len: got %0d want 10", n - lastr); end
    checks++; if (addr !== 4'd15 || eot !== 1'b1 || bot !== 1'b0) begin errors++; $display("FAIL eot_pos: got addr %0d eot %b bot %b want 15 1 0", addr, eot, bot); end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL eot_chars_left: got %0d want 0", sb_q.size()); end
    tick(10);
    checks++; if (busy !== 1'b0 || rd_req !== 1'b0) begin errors++; $display("FAIL eot_refuse: got busy %b req %b want 0 0", busy, rd_req); end
    fwd = 1'b0; sb_on = 1'b0;
    tick();
  endtask

  task automatic test_write_rev;
    int n, wr_seen;
    bit prev;
    logic [AW-1:0] addrs [$];
    pulse_rst();
    for (int i = 0; i < TL; i++) mem[i] = 6'(i);
    fwd = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!(rd_req && addr == 4'd2) && n < 100);
    mag6 = 1'b1; wr_char = 6'o52;
    n = 0;
    do begin tick(); n++; end while (!wr_req && n < 20);
    checks++; if (wr_req !== 1'b1 || rd_req !== 1'b0 || addr !== 4'd3 || wdata !== 6'o52) begin
      errors++; $display("FAIL write_req: got wr %b rd %b addr %0d data %o want 1 0 3 52", wr_req, rd_req, addr, wdata); end
    sb_q.delete();
    sb_q.push_back(6'd4); sb_q.push_back(6'o52); sb_q.push_back(6'd2); sb_q.push_back(6'd1); sb_q.push_back(6'd0);
    sb_on = 1'b1;
    fwd = 1'b0; rev = 1'b1;
    n = 0;
    while (wr_req && n < 10) begin tick(); n++; end
    n = 0; wr_seen = 0; prev = rd_req;
    do begin
      tick(); n++;
      if (wr_req) wr_seen++;
      if (rd_req && !prev) addrs.push_back(addr);
      prev = rd_req;
    end while (!(addrs.size() == 5 && !busy) && n < 200);
    checks++; if (wr_seen !== 0) begin errors++; $display("FAIL rev_no_write: got %0d want 0", wr_seen); end
    checks++; if (addrs.size() !== 5) begin errors++; $display("FAIL rev_slots: got %0d want 5", addrs.size()); end
    for (int i = 0; i < addrs.size(); i++) begin
      checks++; if (addrs[i] !== AW'(4 - i)) begin errors++; $display("FAIL rev_addr%0d: got %0d want %0d", i, addrs[i], 4 - i); end
    end
    checks++; if (sb_q.size() !== 0 || bot !== 1'b1) begin errors++; $display("FAIL rev_end: got left %0d bot %b want 0 1", sb_q.size(), bot); end
    sb_on = 1'b0; rev = 1'b0; mag6 = 1'b0;
    tick();
  endtask

  task automatic test_overrun;
    int n;
    bit dropped;
    sb_q.delete();
    ack_en = 1'b0; sb_on = 1'b1;
    fwd = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!rd_req && n < 20);
    tick(7);
    checks++; if (ovr !== 1'b0 || rd_req !== 1'b1) begin errors++; $display("FAIL ovr_before: got ovr %b req %b want 0 1", ovr, rd_req); end
    tick();
    checks++; if (ovr !== 1'b1 || addr !== 4'd1) begin errors++; $display("FAIL ovr_set: got ovr %b addr %0d want 1 1", ovr, addr); end
    fwd = 1'b0;
    dropped = 1'b0; n = 0;
    do begin tick(); n++; if (!ovr) dropped = 1'b1; end while (busy && n < 100);
    tick(2);
    checks++; if (dropped || ovr !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ovr_sticky: got dropped %b ovr %b busy %b want 0 1 0", dropped, ovr, busy); end
    sb_on = 1'b0; ack_en = 1'b1;
    fwd = 1'b1;
    n = 0; dropped = 1'b0;
    do begin tick(); n++; if (!rd_req && !ovr) dropped = 1'b1; end while (!rd_req && n < 20);
    checks++; if (dropped || ovr !== 1'b0 || rd_req !== 1'b1) begin errors++; $display("FAIL ovr_clear: got early %b ovr %b req %b want 0 0 1", dropped, ovr, rd_req); end
    fwd = 1'b0;
    wait_idle("ovr");
  endtask

  task automatic test_cmd_decode;
    int n, busy_lo;
    bit prev;
    pulse_rst();
    fwd = 1'b1; rev = 1'b1;
    tick(10);
    checks++; if (busy !== 1'b0 || rd_req !== 1'b0) begin errors++; $display("FAIL both_cmd: got busy %b req %b want 0 0", busy, rd_req); end
    fwd = 1'b0;
    tick(10);
    checks++; if (busy !== 1'b0 || rd_req !== 1'b0) begin errors++; $display("FAIL rev_at_bot: got busy %b req %b want 0 0", busy, rd_req); end
    rev = 1'b0; fwd = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!(rd_req && addr == 4'd2) && n < 100);
    fwd = 1'b0; rev = 1'b1;
    n = 0; busy_lo = 0; prev = 1'b1;
    do begin
      tick(); n++;
      if (!busy) busy_lo++;
      if (rd_req && !prev) break;
      prev = rd_req;
    end while (n < 60);
    checks++; if (n !== 17 || addr !== 4'd3) begin errors++; $display("FAIL reversal: got %0d clks addr %0d want 17 3", n, addr); end
    checks++; if (busy_lo !== 1) begin errors++; $display("FAIL reversal_idle: got %0d idle clks want 1", busy_lo); end
    n = 0; prev = rd_req;
    do begin tick(); n++; if (rd_req && !prev) break; prev = rd_req; end while (n < 20);
    checks++; if (addr !== 4'd2 || rd_req !== 1'b1) begin errors++; $display("FAIL reversal_next: got addr %0d req %b want 2 1", addr, rd_req); end
    rev = 1'b0;
    wait_idle("rev");
  endtask

  task automatic test_rst_mid;
    int n = 0;
    ack_en = 1'b0;
    fwd = 1'b1;
    do begin tick(); n++; end while (!rd_req && n < 20);
    @(negedge CLOCK);
    rst = 1'b1;
    #1;
    checks++; if (rd_req !== 1'b0 || wr_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b%b want 00", rd_req, wr_req); end
    checks++; if (addr !== '0 || bot !== 1'b1 || busy !== 1'b0 || ovr !== 1'b0) begin errors++; $display("FAIL rst_mid_state: got addr %0d bot %b busy %b ovr %b want 0 1 0 0", addr, bot, busy, ovr); end
    fwd = 1'b0;
    tick();
    rst = 1'b0; ack_en = 1'b1;
    tick();
  endtask

`ifdef MAG_TAPE_REWIND_EN
  task automatic test_rewind;
    int n = 0;
    pulse_rst();
    fwd = 1'b1;
    do begin tick(); n++; end while (!(rd_req && addr == 4'd9) && n < 200);
    fwd = 1'b0;
    wait_idle("rew_pre");
    checks++; if (addr !== 4'd10) begin errors++; $display("FAIL rew_start_pos: got %0d want 10", addr); end
    rewind = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!busy && n < 5);
    rewind = 1'b0;
    n = 0;
    do begin tick(); n++; end while (addr != 0 && n < 30);
    checks++; if (n !== 10 || busy !== 1'b1) begin errors++; $display("FAIL rew_len: got %0d clks busy %b want 10 1", n, busy); end
    checks++; if (rd_req !== 1'b0 || wr_req !== 1'b0) begin errors++; $display("FAIL rew_no_req: got %b%b want 00", rd_req, wr_req); end
    wait_idle("rew");
    checks++; if (bot !== 1'b1) begin errors++; $display("FAIL rew_bot: got %b want 1", bot); end
  endtask
`endif

  initial begin
    test_reset();
    test_fwd_read();
    test_run_to_eot();
    test_write_rev();
    test_overrun();
    test_cmd_decode();
    test_rst_mid();
`ifdef MAG_TAPE_REWIND_EN
    test_rewind();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
